// File: rtl/fifo_lane_unpacker_if.sv
// Bundle of the FIFO read-side signals and the narrow output beat stream.
// Latency: none; this is wiring only.
// Backpressure: m_ready travels slave->master; read_en has no backpressure.
interface fifo_lane_unpacker_if #(
   parameter int ADR_W  = 2,
   parameter int LANE_W = 72,
   parameter int LANES  = 4
);
   localparam int DATA_W = LANE_W * LANES;

   logic [ADR_W-1:0]  fifo_wadr;
   logic [ADR_W-1:0]  fifo_radr;
   logic              read_en;
   logic [DATA_W-1:0] read_dt;
   logic              m_valid;
   logic              m_ready;
   logic [LANE_W-1:0] m_data;
   logic [1:0]        m_lane;
   logic              m_last;

   // Unpacker's view: reads FIFO state, drives the strobe and the beat stream.
   modport master (
      input  fifo_wadr, fifo_radr, read_dt, m_ready,
      output read_en, m_valid, m_data, m_lane, m_last
   );

   // Environment's view: FIFO plus downstream consumer.
   modport slave (
      output fifo_wadr, fifo_radr, read_dt, m_ready,
      input  read_en, m_valid, m_data, m_lane, m_last
   );
endinterface

// File: rtl/fifo_lane_unpacker.sv
// Pops one wide FIFO word at a time and streams it out as LANES narrow beats.
// Latency: non-empty seen in IDLE at edge N -> read_en in N+1 -> m_valid in N+2+RD_LAT.
// Backpressure: beats held stable while m_ready is low; no new pop until the word is sent.
module fifo_lane_unpacker #(
   parameter int ADR_W  = 2,
   parameter int LANE_W = 72,
   parameter int LANES  = 4,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_lane_unpacker_if.master bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     word_cnt
);
   localparam int         DATA_W    = LANE_W * LANES;
   localparam logic [1:0] LANE_LAST = 2'(LANES - 1);
   localparam logic [1:0] LAT_LAST  = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, SHIFT} state_t;

   state_t            state_q,    state_d;
   logic [1:0]        wcnt_q,     wcnt_d;
   logic [1:0]        lane_q,     lane_d;
   logic [DATA_W-1:0] word_q,     word_d;
   logic              m_valid_q,  m_valid_d;
   logic              m_last_q,   m_last_d;
   logic              read_en_q,  read_en_d;
   logic              busy_q,     busy_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

   logic [ADR_W-1:0]  wadr;
   logic [ADR_W-1:0]  radr;
   logic              non_empty;

   // The writer never fills all 2^ADR_W slots, so equal addresses mean empty even across wrap.
   assign wadr      = bus.fifo_wadr;
   assign radr      = bus.fifo_radr;
   assign non_empty = (wadr != radr);

   // Next-state logic: pop, wait for read data, then shift lanes out LSB-first.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      lane_d     = lane_q;
      word_d     = word_q;
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      read_en_d  = 1'b0;
      word_cnt_d = word_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (non_empty) begin
               state_d   = REQ;
               read_en_d = 1'b1;
            end
         end
         REQ: begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            wcnt_d     = 2'd0;
            state_d    = WAIT;
         end
         WAIT: begin
            if (wcnt_q == LAT_LAST) begin
               word_d    = bus.read_dt;
               lane_d    = 2'd0;
               m_valid_d = 1'b1;
               m_last_d  = (LANES == 1);
               state_d   = SHIFT;
            end else begin
               wcnt_d = wcnt_q + 2'd1;
            end
         end
         SHIFT: begin
            if (m_valid_q && bus.m_ready) begin
               if (lane_q == LANE_LAST) begin
                  // Read address has already advanced past this word, so the test is current.
                  m_valid_d = 1'b0;
                  m_last_d  = 1'b0;
                  lane_d    = 2'd0;
                  if (non_empty) begin
                     state_d   = REQ;
                     read_en_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  lane_d   = lane_q + 2'd1;
                  word_d   = word_q >> LANE_W;
                  m_last_d = ((lane_q + 2'd1) == LANE_LAST);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset discards any partially sent word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wcnt_q     <= 2'd0;
         lane_q     <= 2'd0;
         word_q     <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         read_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         lane_q     <= lane_d;
         word_q     <= word_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         read_en_q  <= read_en_d;
         busy_q     <= busy_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign bus.read_en = read_en_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = word_q[LANE_W-1:0];
   assign bus.m_lane  = lane_q;
   assign bus.m_last  = m_last_q;
   assign busy        = busy_q;
   assign word_cnt    = word_cnt_q;
endmodule

// File: tb/tb_fifo_lane_unpacker.sv
// Scoreboard bench: a FIFO model feeds the unpacker, expected beats are queued at write time.
// Latency: checks first-beat latency and back-to-back streaming.
// Backpressure: m_ready held, toggled and randomized; holds are checked every cycle.
module tb_fifo_lane_unpacker;
   localparam int ADR_W  = 2;
   localparam int LANE_W = 72;
   localparam int LANES  = 4;
   localparam int RD_LAT = 1;
   localparam int CNT_W  = 16;
   localparam int DATA_W = LANE_W * LANES;

   typedef struct packed {
      logic [LANE_W-1:0] d;
      logic [1:0]        lane;
      logic              last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic [CNT_W-1:0] word_cnt;

   fifo_lane_unpacker_if #(.ADR_W(ADR_W), .LANE_W(LANE_W), .LANES(LANES)) bus ();

   fifo_lane_unpacker #(
      .ADR_W(ADR_W), .LANE_W(LANE_W), .LANES(LANES), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   // FIFO model: storage, addresses and a read-latency pipeline.
   logic [DATA_W-1:0] mem [4];
   logic [DATA_W-1:0] pipe [RD_LAT];
   logic [ADR_W-1:0]  wadr = '0;
   logic [ADR_W-1:0]  radr = '0;

   always @(posedge clk) begin
      if (bus.read_en) begin
         pipe[0] <= mem[radr];
         radr    <= radr + 1'b1;
      end
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign bus.fifo_wadr = wadr;
   assign bus.fifo_radr = radr;
   assign bus.read_dt   = pipe[RD_LAT-1];

   // Downstream ready generator: 0 = fixed level, 1 = toggle each cycle, 2 = random.
   int   ready_mode  = 0;
   logic ready_fixed = 1'b0;
   logic m_ready_r   = 1'b0;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       m_ready_r = ~m_ready_r;
         2:       m_ready_r = 1'($urandom_range(0, 1));
         default: m_ready_r = ready_fixed;
      endcase
   end
   assign bus.m_ready = m_ready_r;

   // Scoreboard state.
   beat_t exp_q[$];
   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int popped_total = 0, beats_total = 0, beats_since = LANES;
   int last_read_cyc = 0, first_valid_cyc = 0;
   int pushed_since_rst = 0;
   bit prev_valid = 1'b0, hold_pending = 1'b0;
   beat_t hold_b;

   always @(posedge clk) cyc++;

   task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every transfer is popped against the expected queue; stalled beats must hold.
   always @(negedge clk) begin
      beat_t cur, e;
      cur = '{d: bus.m_data, lane: bus.m_lane, last: bus.m_last};
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending)
            chk(bus.m_valid && cur == hold_b, "stall_hold", {bus.m_valid, cur}, {1'b1, hold_b});
         if (bus.read_en) begin
            chk(wadr != radr, "read_while_empty", 128'(radr), 128'(wadr));
            chk(beats_since >= LANES, "read_spacing", 128'(beats_since), 128'(LANES));
            beats_since   = 0;
            popped_total++;
            last_read_cyc = cyc;
         end
         if (bus.m_valid && !prev_valid) first_valid_cyc = cyc;
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_beat", 128'(cur), 128'(0));
            end else begin
               e = exp_q.pop_front();
               chk(cur == e, "beat", 128'(cur), 128'(e));
            end
            beats_total++;
            beats_since++;
         end
         hold_pending = bus.m_valid && !bus.m_ready;
         hold_b       = cur;
      end
      prev_valid = bus.m_valid;
   end

   // Writes one word once the FIFO has room and queues its lanes, LSBs first.
   task automatic push_word(input logic [DATA_W-1:0] w);
      int guard = 0;
      while (2'(wadr - radr) == 2'd3 && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 2000) chk(1'b0, "push_timeout", 128'(guard), 128'(0));
      mem[wadr] = w;
      wadr      = wadr + 1'b1;
      pushed_since_rst++;
      for (int k = 0; k < LANES; k++)
         exp_q.push_back('{d: LANE_W'(w >> (k * LANE_W)), lane: 2'(k), last: (k == LANES - 1)});
      @(posedge clk); #1;
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   task automatic drain(input string name);
      int guard = 0;
      @(negedge clk); #1;
      while ((exp_q.size() != 0 || busy || wadr != radr) && guard < 3000) begin
         @(negedge clk); #1;
         guard++;
      end
      chk(guard < 3000, {name, "_drain_timeout"}, 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      int p0, b0, guard, discard;
      bit idle_bad, hold_ok;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      chk(bus.m_valid == 1'b0, "rst_m_valid", 128'(bus.m_valid), 128'(0));
      chk(bus.read_en == 1'b0, "rst_read_en", 128'(bus.read_en), 128'(0));
      chk(busy == 1'b0, "rst_busy", 128'(busy), 128'(0));
      chk(word_cnt == '0, "rst_word_cnt", 128'(word_cnt), 128'(0));
      chk(bus.m_data == '0 && bus.m_lane == 2'd0 && bus.m_last == 1'b0, "rst_beat",
          128'({bus.m_data, bus.m_lane, bus.m_last}), 128'(0));
      rst = 1'b0;

      // Empty FIFO stays quiet.
      idle_bad = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (bus.read_en || bus.m_valid || busy) idle_bad = 1'b1;
      end
      chk(!idle_bad, "idle_quiet", 128'(idle_bad), 128'(0));

      // Four words with m_ready held high.
      ready_fixed = 1'b1;
      p0 = popped_total;
      push_word(288'd10);
      push_word(288'd30);
      push_word(288'd0);
      push_word(288'd99);
      drain("t1");
      chk(popped_total - p0 == 4, "t1_pops", 128'(popped_total - p0), 128'(4));
      chk(word_cnt == 16'd4, "t1_word_cnt", 128'(word_cnt), 128'(4));
      chk(busy == 1'b0, "t1_busy", 128'(busy), 128'(0));

      // Stalled first beat, then four consecutive beats.
      ready_fixed = 1'b0;
      @(posedge clk); #2;
      push_word({72'h4, 72'h3, 72'h2, 72'h1});
      guard = 0;
      while (!bus.m_valid && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      chk(bus.m_valid, "t3_valid_timeout", 128'(bus.m_valid), 128'(1));
      chk(first_valid_cyc - last_read_cyc == 1 + RD_LAT, "t3_latency",
          128'(first_valid_cyc - last_read_cyc), 128'(1 + RD_LAT));
      hold_ok = 1'b1;
      repeat (5) begin
         if (!(bus.m_valid && bus.m_data == 72'h1 && bus.m_lane == 2'd0)) hold_ok = 1'b0;
         @(negedge clk); #1;
      end
      chk(hold_ok, "t3_hold_lane0", 128'(hold_ok), 128'(1));
      ready_fixed = 1'b1;
      @(posedge clk); #2;
      b0 = beats_total;
      repeat (4) @(negedge clk);
      #1;
      chk(beats_total - b0 == 4 && exp_q.size() == 0, "t3_back_to_back", 128'(beats_total - b0), 128'(4));
      drain("t3");

      // Toggling ready across three words.
      ready_mode = 1;
      p0 = popped_total;
      repeat (3) push_word(rand_word());
      drain("t4");
      chk(popped_total - p0 == 3, "t4_pops", 128'(popped_total - p0), 128'(3));

      // Seven words with random gaps and random ready; addresses wrap.
      ready_mode = 2;
      repeat (7) begin
         repeat ($urandom_range(0, 6)) @(posedge clk);
         #1;
         push_word(rand_word());
      end
      drain("t5");
      chk(word_cnt == CNT_W'(pushed_since_rst), "t5_word_cnt", 128'(word_cnt), 128'(pushed_since_rst));
      chk(radr == wadr, "t5_addr_equal", 128'(radr), 128'(wadr));

      // Reset one cycle after the second beat of a word.
      ready_mode  = 0;
      ready_fixed = 1'b1;
      @(posedge clk); #2;
      b0 = beats_total;
      push_word(rand_word());
      guard = 0;
      while (beats_total - b0 < 2 && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      chk(beats_total - b0 == 2, "t6_two_beats", 128'(beats_total - b0), 128'(2));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      discard = popped_total * LANES - beats_total;
      repeat (discard) begin
         void'(exp_q.pop_front());
         beats_total++;
      end
      beats_since      = LANES;
      pushed_since_rst = 0;
      rst = 1'b0;
      @(negedge clk);
      chk(bus.m_valid == 1'b0, "t6_valid_after_rst", 128'(bus.m_valid), 128'(0));
      chk(word_cnt == '0, "t6_word_cnt_after_rst", 128'(word_cnt), 128'(0));
      chk(busy == 1'b0, "t6_busy_after_rst", 128'(busy), 128'(0));
      @(posedge clk); #1;
      push_word(rand_word());
      drain("t6");
      chk(word_cnt == 16'd1, "t6_word_cnt_final", 128'(word_cnt), 128'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_chk);
      $fatal(1, "watchdog");
   end
endmodule
